// File: rtl/morse_sequencer.sv
// Morse character sequencer: plays up to five dot/dash symbols with standard
// unit timing.
// It drives registered tone enables for the PWM tone generator.
module morse_sequencer #(
  parameter int unsigned UNIT_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] sym_bits,
  input  logic [2:0] sym_count,
  input  logic       abort,
  output logic       dot,
  output logic       dash,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP,
    CHAR_GAP
  } state_e;

  // Counter reload values are duration-1 so a phase ends when the count hits 0.
  localparam logic [31:0] UNIT_LAST   = 32'(UNIT_CYCLES - 1);
  localparam logic [31:0] TRIPLE_LAST = 32'(3 * UNIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [2:0]  len_q,   len_d;
  logic [4:0]  pat_q,   pat_d;
  logic        dot_q,   dot_d;
  logic        dash_q,  dash_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic [2:0]  len_in;
  logic [2:0]  idx_next;
  logic [4:0]  pat_sel;
  logic        bit_next;

  // Clamp the requested symbol count to 5 and precompute the next symbol index.
  always_comb begin
    len_in   = (sym_count > 3'd5) ? 3'd5 : sym_count;
    idx_next = 3'(idx_q + 3'd1);
  end

  // Next-state, counter and pattern control; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    pat_sel = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pat_d = sym_bits;
          len_d = len_in;
          idx_d = '0;
          if (len_in == 3'd0) begin
            // Zero-length character: a single CHAR_GAP cycle yields done next.
            state_d = CHAR_GAP;
            cnt_d   = '0;
          end else begin
            state_d = TONE;
            cnt_d   = sym_bits[0] ? TRIPLE_LAST : UNIT_LAST;
          end
        end
      end
      TONE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (idx_next < len_q) begin
          state_d = GAP;
          cnt_d   = UNIT_LAST;
        end else begin
          state_d = CHAR_GAP;
          cnt_d   = TRIPLE_LAST;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          state_d = TONE;
          idx_d   = idx_next;
          pat_sel = pat_q >> idx_next;
          cnt_d   = pat_sel[0] ? TRIPLE_LAST : UNIT_LAST;
        end
      end
      CHAR_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Registered output decode from the upcoming state and symbol.
  always_comb begin
    bit_next = pat_d[idx_d < 3'd5 ? idx_d : 3'd0];
    dot_d    = (state_d == TONE) && !bit_next;
    dash_d   = (state_d == TONE) &&  bit_next;
    busy_d   = (state_d != IDLE);
  end

  // State and output registers; reset silences the tone outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dot  = dot_q;
  assign dash = dash_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer with UNIT_CYCLES=4.
// Each accepted character pushes its full per-cycle {dot,dash,busy,done}
// waveform; the monitor pops one entry per cycle and expects all-zero when empty.
module tb_morse_sequencer;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] sym_bits = '0;
  logic [2:0] sym_count = '0;
  logic       abort = 1'b0;
  logic       dot, dash, busy, done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        mon_en   = 1'b0;
  logic [3:0]  exp_q[$];

  morse_sequencer #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sym_bits(sym_bits),
    .sym_count(sym_count), .abort(abort), .dot(dot), .dash(dash),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Build the expected waveform of one character from Morse timing rules.
  task automatic push_char(input logic [4:0] bits, input logic [2:0] cnt);
    int unsigned c;
    c = (cnt > 3'd5) ? 5 : int'(cnt);
    if (c == 0) begin
      exp_q.push_back(4'b0010);
    end else begin
      for (int unsigned i = 0; i < c; i++) begin
        for (int unsigned k = 0; k < (bits[i] ? 3 * U : U); k++)
          exp_q.push_back(bits[i] ? 4'b0110 : 4'b1010);
        for (int unsigned k = 0; k < ((i == c - 1) ? 3 * U : U); k++)
          exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0001);
  endtask

  // Waits (bounded) until all expected output is consumed, then presents start for one edge.
  task automatic send_char(input logic [4:0] bits, input logic [2:0] cnt);
    int unsigned waited;
    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
    end while (exp_q.size() != 0 && waited < 500);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    sym_bits  = bits;
    sym_count = cnt;
    start     = 1'b1;
    push_char(bits, cnt);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Per-cycle output comparison against the scoreboard.
  always @(negedge clk) begin
    logic [3:0] e;
    if (mon_en) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
      check("outs", {28'd0, dot, dash, busy, done}, {28'd0, e});
    end
  end

  initial begin
    // Outputs held low under reset.
    #12;
    check("rst_outs", {28'd0, dot, dash, busy, done}, 32'd0);
    @(negedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Letter A with an ignored start pulse mid-dash.
    send_char(5'b00010, 3'd2);
    repeat (9) begin @(negedge clk); #1; end
    sym_bits = 5'b11111; sym_count = 3'd0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;

    // Zero-length character back-to-back with the done of A.
    send_char(5'b10101, 3'd0);
    // Letter E, then the count clamp case.
    send_char(5'b00000, 3'd1);
    send_char(5'b11111, 3'd7);

    // Letter T aborted in its third dash cycle.
    send_char(5'b00001, 3'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    abort = 1'b1;
    exp_q.delete();
    @(negedge clk); #1;
    abort = 1'b0;

    // Abort in IDLE blocks a simultaneous start.
    sym_bits = 5'b00001; sym_count = 3'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (2) begin @(negedge clk); #1; end

    // Reset mid-dash silences outputs without a clock edge.
    send_char(5'b00001, 3'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("async_rst_outs", {28'd0, dot, dash, busy, done}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Normal character after reset release.
    send_char(5'b00010, 3'd2);
    repeat (45) begin @(negedge clk); #1; end
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
